// File: rtl/uart_pkg.sv
// Shared UART definitions for the word transmitter and the upstream receiver.
// Defining UART_TX_PARITY_EN adds the PARITY state to the transmit FSM encoding.
package uart_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_word_tx_if.sv
// Word-level handshake between the FFT/FIR core (master) and the UART word transmitter (slave).
interface uart_word_tx_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              tx_serial;
  logic              tx_done;
  logic              tx_busy;
  logic              tx_overrun;

  modport master (
    output data_in, data_valid,
    input  tx_serial, tx_done, tx_busy, tx_overrun
  );

  modport slave (
    input  data_in, data_valid,
    output tx_serial, tx_done, tx_busy, tx_overrun
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// clear_i holds the count at zero so a new frame starts on a clean bit boundary.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rstb,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    bit_tick_o = !clear_i && (cnt_q == LAST);
    cnt_d      = cnt_q + CW'(1);
    if (clear_i || bit_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Sends each accepted 16-bit word as two back-to-back UART frames, low byte first.
// Default frame is 8N1; defining UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 16
) (
  input  logic           clk,
  input  logic           rstb,
  uart_word_tx_if.slave  bus
);

  import uart_pkg::*;

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_BYTE = 1'(UART_BYTES_PER_WORD - 1);

  uart_tx_state_t    state_q;
  logic [DATA_W-1:0] word_q;
  logic              byte_idx_q;
  logic [2:0]        bit_idx_q;
  logic              dv_q;
  logic              done_pend_q;
  logic              tx_serial_q;
  logic              tx_done_q;
  logic              tx_busy_q;
  logic              overrun_q;

  logic              dv_rise;
  logic              accept;
  logic              bit_tick;
  logic              line_d;
  logic [7:0]        cur_byte;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .rstb       (rstb),
    .clear_i    (state_q == IDLE),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    dv_rise  = bus.data_valid && !dv_q;
    accept   = dv_rise && (state_q == IDLE);
    cur_byte = byte_idx_q ? word_q[UART_DATA_BITS +: UART_DATA_BITS]
                          : word_q[0 +: UART_DATA_BITS];
    line_d   = 1'b1;
    case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = cur_byte[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = ^cur_byte;
`endif
      default: line_d = 1'b1;
    endcase
  end

  // Word held only for the frame in flight; later data_in changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q <= bus.data_in;
    end
  end

  // Line and done are registered one cycle behind the state, so the start bit
  // appears on the edge after accept and tx_done follows the last stop bit.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      byte_idx_q  <= 1'b0;
      bit_idx_q   <= '0;
      dv_q        <= 1'b0;
      done_pend_q <= 1'b0;
      tx_serial_q <= 1'b1;
      tx_done_q   <= 1'b0;
      tx_busy_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dv_q        <= bus.data_valid;
      tx_serial_q <= line_d;
      tx_done_q   <= done_pend_q;
      done_pend_q <= 1'b0;
      if (done_pend_q) begin
        tx_busy_q <= 1'b0;
      end
      if (dv_rise && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            byte_idx_q <= 1'b0;
            bit_idx_q  <= '0;
            tx_busy_q  <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            bit_idx_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            if (byte_idx_q != LAST_BYTE) begin
              byte_idx_q <= byte_idx_q + 1'b1;
              state_q    <= START;
            end else begin
              done_pend_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_serial  = tx_serial_q;
  assign bus.tx_done    = tx_done_q;
  assign bus.tx_busy    = tx_busy_q;
  assign bus.tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: random words checked against a frame-level line model.
module tb_uart_word_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int WORD_CYC = 88;
`else
  localparam int WORD_CYC = 80;
`endif
  localparam int CAP_MAX = 256;

  logic clk  = 1'b0;
  logic rstb = 1'b1;

  uart_word_tx_if #(.DATA_W(16)) bus ();

  uart_word_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (16)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_line[$];
  logic cap_line[CAP_MAX];
  logic cap_busy[CAP_MAX];
  logic cap_done[CAP_MAX];

  // Expected line level for every clock after accept, built from the frame format.
  function automatic void build_model(input logic [15:0] w);
    logic [7:0] b;
    logic       bits[$];
    exp_line.delete();
    for (int n = 0; n < 2; n++) begin
      b = w[8*n +: 8];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      bits.push_back(^b);
`endif
      bits.push_back(1'b1);
    end
    foreach (bits[j]) repeat (CPB) exp_line.push_back(bits[j]);
  endfunction

  function automatic int line_errors(input int n);
    int e = 0;
    for (int k = 1; k <= n; k++) if (cap_line[k] !== exp_line[k-1]) e++;
    return e;
  endfunction

  function automatic int busy_errors(input int n, input int w);
    int e = 0;
    for (int k = 1; k <= n; k++) if (cap_busy[k] !== ((k <= w) ? 1'b1 : 1'b0)) e++;
    return e;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 1; k <= n; k++) if (cap_done[k] === 1'b1) return k;
    return 0;
  endfunction

  function automatic int done_count(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (cap_done[k] === 1'b1) c++;
    return c;
  endfunction

  task automatic do_accept(input logic [15:0] w, input bit keep);
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    if (!keep) bus.data_valid = 1'b0;
  endtask

  task automatic capture(input int ncyc, input int pulse_at, input bit scramble,
                         input bit chain, input logic [15:0] next_word);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      cap_line[k] = bus.tx_serial;
      cap_busy[k] = bus.tx_busy;
      cap_done[k] = bus.tx_done;
      if (scramble) bus.data_in = 16'($urandom);
      if (k == pulse_at) bus.data_valid = 1'b1;
      else if (k == pulse_at + 1) bus.data_valid = 1'b0;
      if (chain && k == ncyc) begin
        bus.data_in    = next_word;
        bus.data_valid = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #2 rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.tx_serial !== 1'b1) $display("FAIL reset_serial: got %b want 1", bus.tx_serial); else n_pass++;
    n_checks++; if (bus.tx_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.tx_done); else n_pass++;
    n_checks++; if (bus.tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.tx_busy); else n_pass++;
    n_checks++; if (bus.tx_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.tx_overrun); else n_pass++;
    rstb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.tx_serial !== 1'b1) $display("FAIL idle_serial: got %b want 1", bus.tx_serial); else n_pass++;
  endtask

  task automatic test_basic_word();
    int w;
    build_model(16'hA55A);
    w = exp_line.size();
    do_accept(16'hA55A, 1'b0);
    capture(w + 4, -1, 1'b0, 1'b0, 16'h0);
    n_checks++; if (line_errors(w) !== 0) $display("FAIL basic_line: %0d bad samples want 0", line_errors(w)); else n_pass++;
    n_checks++; if (first_done(w + 4) !== WORD_CYC + 1) $display("FAIL basic_done_cycle: got %0d want %0d", first_done(w + 4), WORD_CYC + 1); else n_pass++;
    n_checks++; if (done_count(w + 4) !== 1) $display("FAIL basic_done_count: got %0d want 1", done_count(w + 4)); else n_pass++;
    n_checks++; if (busy_errors(w + 4, w) !== 0) $display("FAIL basic_busy: %0d bad samples want 0", busy_errors(w + 4, w)); else n_pass++;
  endtask

  task automatic test_random_words();
    logic [15:0] v;
    int w;
    for (int r = 0; r < 3; r++) begin
      v = 16'($urandom);
      build_model(v);
      w = exp_line.size();
      do_accept(v, 1'b0);
      capture(w + 3, -1, 1'b1, 1'b0, 16'h0);
      n_checks++; if (line_errors(w) !== 0) $display("FAIL random_line[%h]: %0d bad samples want 0", v, line_errors(w)); else n_pass++;
      n_checks++; if (first_done(w + 3) !== w + 1) $display("FAIL random_done[%h]: got %0d want %0d", v, first_done(w + 3), w + 1); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    int w;
    v = 16'($urandom);
    build_model(v);
    w = exp_line.size();
    do_accept(v, 1'b0);
    capture(w + 1, -1, 1'b0, 1'b1, 16'h00FF);
    n_checks++; if (line_errors(w) !== 0) $display("FAIL b2b_first_line: %0d bad samples want 0", line_errors(w)); else n_pass++;
    n_checks++; if (cap_done[w + 1] !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", cap_done[w + 1]); else n_pass++;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    n_checks++; if (bus.tx_busy !== 1'b1) $display("FAIL b2b_accept_busy: got %b want 1", bus.tx_busy); else n_pass++;
    build_model(16'h00FF);
    capture(w + 3, -1, 1'b0, 1'b0, 16'h0);
    n_checks++; if (line_errors(w) !== 0) $display("FAIL b2b_second_line: %0d bad samples want 0", line_errors(w)); else n_pass++;
    n_checks++; if (done_count(w + 3) !== 1) $display("FAIL b2b_second_done: got %0d want 1", done_count(w + 3)); else n_pass++;
  endtask

  task automatic test_held_valid();
    logic [15:0] v;
    int w;
    v = 16'($urandom);
    build_model(v);
    w = exp_line.size();
    do_accept(v, 1'b1);
    capture(199, -1, 1'b0, 1'b0, 16'h0);
    bus.data_valid = 1'b0;
    n_checks++; if (line_errors(w) !== 0) $display("FAIL hold_line: %0d bad samples want 0", line_errors(w)); else n_pass++;
    n_checks++; if (done_count(199) !== 1) $display("FAIL hold_done_count: got %0d want 1", done_count(199)); else n_pass++;
    n_checks++; if (busy_errors(199, w) !== 0) $display("FAIL hold_busy: %0d bad samples want 0", busy_errors(199, w)); else n_pass++;
    n_checks++; if (bus.tx_overrun !== 1'b0) $display("FAIL hold_overrun: got %b want 0", bus.tx_overrun); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_overrun();
    logic [15:0] v;
    int w;
    n_checks++; if (bus.tx_overrun !== 1'b0) $display("FAIL overrun_before: got %b want 0", bus.tx_overrun); else n_pass++;
    v = 16'($urandom);
    build_model(v);
    w = exp_line.size();
    do_accept(v, 1'b0);
    capture(w + 4, 10, 1'b0, 1'b0, 16'h0);
    n_checks++; if (line_errors(w) !== 0) $display("FAIL overrun_line: %0d bad samples want 0", line_errors(w)); else n_pass++;
    n_checks++; if (done_count(w + 4) !== 1) $display("FAIL overrun_done_count: got %0d want 1", done_count(w + 4)); else n_pass++;
    n_checks++; if (bus.tx_overrun !== 1'b1) $display("FAIL overrun_flag: got %b want 1", bus.tx_overrun); else n_pass++;
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (bus.tx_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", bus.tx_overrun); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] v;
    int w;
    int nd;
    v = 16'($urandom) & 16'hFFFD;
    do_accept(v, 1'b0);
    repeat (3 * CPB) @(posedge clk);
    #1;
    n_checks++; if (bus.tx_serial !== 1'b0) $display("FAIL midreset_pre_line: got %b want 0", bus.tx_serial); else n_pass++;
    rstb = 1'b0;
    #1;
    n_checks++; if (bus.tx_serial !== 1'b1) $display("FAIL midreset_line: got %b want 1", bus.tx_serial); else n_pass++;
    n_checks++; if (bus.tx_busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", bus.tx_busy); else n_pass++;
    n_checks++; if (bus.tx_overrun !== 1'b0) $display("FAIL midreset_overrun: got %b want 0", bus.tx_overrun); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    rstb = 1'b1;
    nd = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (bus.tx_done === 1'b1 || bus.tx_serial !== 1'b1) nd++;
    end
    n_checks++; if (nd !== 0) $display("FAIL midreset_quiet: got %0d active cycles want 0", nd); else n_pass++;
    build_model(16'h1234);
    w = exp_line.size();
    do_accept(16'h1234, 1'b0);
    capture(w + 3, -1, 1'b0, 1'b0, 16'h0);
    n_checks++; if (line_errors(w) !== 0) $display("FAIL midreset_1234_line: %0d bad samples want 0", line_errors(w)); else n_pass++;
    n_checks++; if (first_done(w + 3) !== WORD_CYC + 1) $display("FAIL midreset_1234_done: got %0d want %0d", first_done(w + 3), WORD_CYC + 1); else n_pass++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int w;
    build_model(16'h0701);
    w = exp_line.size();
    do_accept(16'h0701, 1'b0);
    capture(w + 3, -1, 1'b0, 1'b0, 16'h0);
    n_checks++; if (line_errors(w) !== 0) $display("FAIL parity_line: %0d bad samples want 0", line_errors(w)); else n_pass++;
    n_checks++; if (cap_line[9*CPB + 2] !== 1'b1) $display("FAIL parity_byte0: got %b want 1", cap_line[9*CPB + 2]); else n_pass++;
    n_checks++; if (cap_line[20*CPB + 2] !== 1'b1) $display("FAIL parity_byte1: got %b want 1", cap_line[20*CPB + 2]); else n_pass++;
    n_checks++; if (first_done(w + 3) !== 89) $display("FAIL parity_done: got %0d want 89", first_done(w + 3)); else n_pass++;
  endtask
`endif

  initial begin
    bus.data_in    = 16'h0;
    bus.data_valid = 1'b0;
    test_reset();
    test_basic_word();
    test_random_words();
    test_back_to_back();
    test_held_valid();
    test_overrun();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
